// File: rtl/dc_bp_pkg.sv
// Shared types and helpers for the dual-clock FIFO back-pressure monitor.
//   bp_state_t : per-channel CSR polling state
//   CSR_DATA_W : Avalon-MM CSR data width
//   hyst_next  : next almost_full value for a freshly read fill level
package dc_bp_pkg;

  localparam int unsigned CSR_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAP   = 2'd2
  } bp_state_t;

  // Between the two thresholds the previous decision is held.
  function automatic logic hyst_next(
    input logic [CSR_DATA_W-1:0] lvl,
    input logic                  cur,
    input logic [CSR_DATA_W-1:0] hi,
    input logic [CSR_DATA_W-1:0] lo
  );
    logic res;
    res = cur;
    if (lvl >= hi) begin
      res = 1'b1;
    end else if (lvl <= lo) begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dc_back_pressure_mc_channel.sv
// Single-channel fill-level poller with hysteretic almost_full.
// Repeatedly reads the FIFO fill-level CSR over an Avalon-MM read master,
// tracks the last valid level, and raises almost_full with hysteresis.
// A read whose response does not arrive within TIMEOUT cycles sets a sticky
// timeout_err and forces almost_full high until the next valid read.
// Ports:
//   clk, rst           : core clock, synchronous active-high reset
//   csr_read           : read request (registered)
//   csr_waitrequest    : slave stall
//   csr_readdata       : fill level returned by the slave
//   csr_readdatavalid  : read response strobe
//   almost_full        : back-pressure to the producer
//   timeout_err        : sticky read-timeout flag
//   level              : last valid fill level
//   assert_cnt         : saturating count of almost_full rising edges
module dc_bp_channel
  import dc_bp_pkg::*;
#(
  parameter int unsigned HIGH_LEVEL = 490,
  parameter int unsigned LOW_LEVEL  = 450,
  parameter int unsigned POLL_GAP   = 0,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  csr_read,
  input  logic                  csr_waitrequest,
  input  logic [CSR_DATA_W-1:0] csr_readdata,
  input  logic                  csr_readdatavalid,
  output logic                  almost_full,
  output logic                  timeout_err,
  output logic [CSR_DATA_W-1:0] level,
  output logic [CNT_W-1:0]      assert_cnt
);

  localparam int unsigned TMR_W = (TIMEOUT > 2)  ? $clog2(TIMEOUT)  : 1;
  localparam int unsigned GAP_W = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam bp_state_t   ST_AFTER = (POLL_GAP > 0) ? ST_GAP : ST_ISSUE;

  bp_state_t        st, st_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic             af_next;
  logic             capture;
  logic             tout_hit;

  always_comb begin
    st_next    = st;
    timer_next = timer;
    gap_next   = gap_cnt;
    af_next    = almost_full;
    capture    = 1'b0;
    tout_hit   = 1'b0;
    case (st)
      ST_ISSUE: begin
        // csr_read is low for the first cycle out of reset, so it gates acceptance.
        if (csr_read && !csr_waitrequest) begin
          st_next    = ST_WAIT;
          timer_next = '0;
        end
      end
      ST_WAIT: begin
        if (csr_readdatavalid) begin
          capture  = 1'b1;
          af_next  = hyst_next(csr_readdata, almost_full,
                               CSR_DATA_W'(HIGH_LEVEL), CSR_DATA_W'(LOW_LEVEL));
          st_next  = ST_AFTER;
          gap_next = '0;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          // Fail-safe: with no fresh level, assume the FIFO may be full.
          tout_hit = 1'b1;
          af_next  = 1'b1;
          st_next  = ST_AFTER;
          gap_next = '0;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
          st_next = ST_ISSUE;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      default: st_next = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_ISSUE;
      csr_read    <= 1'b0;
      timer       <= '0;
      gap_cnt     <= '0;
      almost_full <= 1'b0;
      timeout_err <= 1'b0;
      level       <= '0;
      assert_cnt  <= '0;
    end else begin
      st          <= st_next;
      csr_read    <= (st_next == ST_ISSUE);
      timer       <= timer_next;
      gap_cnt     <= gap_next;
      almost_full <= af_next;
      if (tout_hit) begin
        timeout_err <= 1'b1;
      end
      if (capture) begin
        level <= csr_readdata;
      end
      if (af_next && !almost_full && (assert_cnt != '1)) begin
        assert_cnt <= assert_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dc_back_pressure_mc.sv
// Multi-channel hysteretic back-pressure generator for dual-clock FIFOs.
// Each channel independently polls its FIFO's fill-level CSR and drives a
// per-channel almost_full; almost_full_any is the registered OR of them.
// Ports:
//   clk, rst            : core clock, synchronous active-high reset
//   csr_address         : per-channel CSR address (constant LEVEL_ADDR)
//   csr_read            : per-channel read request
//   csr_write           : tied low
//   csr_writedata       : tied low
//   csr_waitrequest     : per-channel slave stall
//   csr_readdata        : per-channel fill level (32 bits each)
//   csr_readdatavalid   : per-channel response strobe
//   almost_full         : per-channel back-pressure
//   almost_full_any     : OR of almost_full, one cycle later
//   timeout_err         : per-channel sticky read-timeout flag
//   level               : per-channel last valid fill level
//   assert_cnt          : per-channel almost_full rising-edge counters
module dc_back_pressure_mc
  import dc_bp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned HIGH_LEVEL = 490,
  parameter int unsigned LOW_LEVEL  = 450,
  parameter int unsigned ADDR_W     = 1,
  parameter int unsigned LEVEL_ADDR = 0,
  parameter int unsigned POLL_GAP   = 0,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [NUM_CH*ADDR_W-1:0]       csr_address,
  output logic [NUM_CH-1:0]              csr_read,
  output logic [NUM_CH-1:0]              csr_write,
  output logic [NUM_CH*CSR_DATA_W-1:0]   csr_writedata,
  input  logic [NUM_CH-1:0]              csr_waitrequest,
  input  logic [NUM_CH*CSR_DATA_W-1:0]   csr_readdata,
  input  logic [NUM_CH-1:0]              csr_readdatavalid,
  output logic [NUM_CH-1:0]              almost_full,
  output logic                           almost_full_any,
  output logic [NUM_CH-1:0]              timeout_err,
  output logic [NUM_CH*CSR_DATA_W-1:0]   level,
  output logic [NUM_CH*CNT_W-1:0]        assert_cnt
);

  assign csr_write     = '0;
  assign csr_writedata = '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign csr_address[g*ADDR_W +: ADDR_W] = ADDR_W'(LEVEL_ADDR);

    dc_bp_channel #(
      .HIGH_LEVEL (HIGH_LEVEL),
      .LOW_LEVEL  (LOW_LEVEL),
      .POLL_GAP   (POLL_GAP),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk               (clk),
      .rst               (rst),
      .csr_read          (csr_read[g]),
      .csr_waitrequest   (csr_waitrequest[g]),
      .csr_readdata      (csr_readdata[g*CSR_DATA_W +: CSR_DATA_W]),
      .csr_readdatavalid (csr_readdatavalid[g]),
      .almost_full       (almost_full[g]),
      .timeout_err       (timeout_err[g]),
      .level             (level[g*CSR_DATA_W +: CSR_DATA_W]),
      .assert_cnt        (assert_cnt[g*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_any <= 1'b0;
    end else begin
      almost_full_any <= |almost_full;
    end
  end

endmodule

// File: tb/tb_dc_back_pressure_mc.sv
module tb_dc_back_pressure_mc;

  localparam int NCH = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [NCH-1:0]     csr_address;
  logic [NCH-1:0]     csr_read;
  logic [NCH-1:0]     csr_write;
  logic [NCH*32-1:0]  csr_writedata;
  logic [NCH-1:0]     wr   = '0;
  logic [NCH*32-1:0]  rdata = '0;
  logic [NCH-1:0]     rdv  = '0;
  logic [NCH-1:0]     almost_full;
  logic               almost_full_any;
  logic [NCH-1:0]     timeout_err;
  logic [NCH*32-1:0]  level;
  logic [NCH*CW-1:0]  assert_cnt;

  logic        g_address;
  logic        g_read;
  logic        g_write;
  logic [31:0] g_writedata;
  logic        g_wr = 1'b0;
  logic [31:0] g_rdata = '0;
  logic        g_rdv = 1'b0;
  logic        g_af;
  logic        g_any;
  logic        g_tout;
  logic [31:0] g_level;
  logic [31:0] g_cnt;

  logic [NCH-1:0] hold = '0;
  logic [31:0]    resp_data [NCH];
  logic           m_af  [NCH];
  int             m_cnt [NCH];

  typedef struct {
    logic        af;
    logic [3:0]  cnt;
    logic [31:0] lvl;
  } exp_t;
  exp_t sb[$];

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  dc_back_pressure_mc #(
    .NUM_CH (NCH),
    .CNT_W  (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_waitrequest   (wr),
    .csr_readdata      (rdata),
    .csr_readdatavalid (rdv),
    .almost_full       (almost_full),
    .almost_full_any   (almost_full_any),
    .timeout_err       (timeout_err),
    .level             (level),
    .assert_cnt        (assert_cnt)
  );

  dc_back_pressure_mc #(
    .NUM_CH   (1),
    .POLL_GAP (5)
  ) dut_gap (
    .clk               (clk),
    .rst               (rst),
    .csr_address       (g_address),
    .csr_read          (g_read),
    .csr_write         (g_write),
    .csr_writedata     (g_writedata),
    .csr_waitrequest   (g_wr),
    .csr_readdata      (g_rdata),
    .csr_readdatavalid (g_rdv),
    .almost_full       (g_af),
    .almost_full_any   (g_any),
    .timeout_err       (g_tout),
    .level             (g_level),
    .assert_cnt        (g_cnt)
  );

  // Slave model: answers every accepted read one cycle later unless held.
  initial begin
    logic [NCH-1:0] acc;
    logic           gacc;
    for (int unsigned i = 0; i < NCH; i++) resp_data[i] = '0;
    forever begin
      @(negedge clk);
      #1;
      acc  = csr_read & ~wr & ~hold;
      gacc = g_read & ~g_wr;
      @(posedge clk);
      #1;
      for (int unsigned i = 0; i < NCH; i++) begin
        rdv[i] = acc[i];
        if (acc[i]) rdata[i*32 +: 32] = resp_data[i];
      end
      g_rdv   = gacc;
      g_rdata = 32'd300;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic reset_model();
    for (int unsigned i = 0; i < NCH; i++) begin
      m_af[i]  = 1'b0;
      m_cnt[i] = 0;
    end
  endtask

  // Drives one fill level on a channel, queues the expected result, and
  // waits until the DUT has sampled that response.
  task automatic send_level(input int ch, input logic [31:0] v, output bit ok);
    exp_t e;
    resp_data[ch] = v;
    if (v >= 32'd490) begin
      if (!m_af[ch] && m_cnt[ch] < 15) m_cnt[ch]++;
      m_af[ch] = 1'b1;
    end else if (v <= 32'd450) begin
      m_af[ch] = 1'b0;
    end
    e.af  = m_af[ch];
    e.cnt = 4'(m_cnt[ch]);
    e.lvl = v;
    sb.push_back(e);
    ok = 1'b0;
    for (int unsigned i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rdv[ch] && rdata[ch*32 +: 32] == v) begin
        @(negedge clk);
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_rd;
    rst = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    cmp++;
    if ({csr_read, almost_full, almost_full_any, timeout_err, csr_write} !== '0) begin
      err++;
      $display("FAIL reset_ctrl: got %b expected 0", {csr_read, almost_full, almost_full_any, timeout_err, csr_write});
    end
    cmp++;
    if (level !== '0) begin
      err++; $display("FAIL reset_level: got %h expected 0", level);
    end
    cmp++;
    if (assert_cnt !== '0) begin
      err++; $display("FAIL reset_cnt: got %h expected 0", assert_cnt);
    end
    cmp++;
    if (csr_writedata !== '0 || csr_address !== '0) begin
      err++; $display("FAIL reset_wdata_addr: got %h/%b expected 0/0", csr_writedata, csr_address);
    end
    rst = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_rd = (i % 2 == 0) ? 4'hF : 4'h0;
      cmp++;
      if (csr_read !== exp_rd) begin
        err++; $display("FAIL read_pulse[%0d]: got %b expected %b", i, csr_read, exp_rd);
      end
    end
    repeat (4) @(negedge clk);
    cmp++;
    if (almost_full !== '0 || level !== '0 || assert_cnt !== '0) begin
      err++; $display("FAIL zero_poll: got af=%b lvl=%h cnt=%h expected all 0", almost_full, level, assert_cnt);
    end
  endtask

  task automatic test_hysteresis();
    logic [31:0] vals [5];
    bit          ok;
    exp_t        e;
    vals = '{32'd489, 32'd490, 32'd470, 32'd451, 32'd450};
    for (int unsigned i = 0; i < 5; i++) begin
      send_level(1, vals[i], ok);
      e = sb.pop_front();
      cmp++;
      if (!ok) begin
        err++; $display("FAIL hyst_resp[%0d]: got no response expected level %0d", i, vals[i]);
      end else if ({almost_full[1], assert_cnt[4 +: 4], level[32 +: 32]} !== {e.af, e.cnt, e.lvl}) begin
        err++;
        $display("FAIL hyst[%0d]: got af=%b cnt=%0d lvl=%0d expected af=%b cnt=%0d lvl=%0d",
                 i, almost_full[1], assert_cnt[4 +: 4], level[32 +: 32], e.af, e.cnt, e.lvl);
      end
      if (i == 1 || i == 4) begin
        cmp++;
        if (almost_full_any !== (i == 4)) begin
          err++; $display("FAIL any_lag[%0d]: got %b expected %b", i, almost_full_any, (i == 4));
        end
        @(negedge clk);
        cmp++;
        if (almost_full_any !== (i == 1)) begin
          err++; $display("FAIL any_follow[%0d]: got %b expected %b", i, almost_full_any, (i == 1));
        end
      end
    end
  endtask

  task automatic test_waitrequest();
    bit found = 1'b0;
    for (int unsigned i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (csr_read[2]) found = 1'b1;
    end
    cmp++;
    if (!found) begin
      err++; $display("FAIL wr_start: got no csr_read[2] expected 1");
    end
    wr[2] = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      cmp++;
      if (csr_read[2] !== 1'b1) begin
        err++; $display("FAIL wr_hold[%0d]: got csr_read=%b expected 1", i, csr_read[2]);
      end
    end
    cmp++;
    if (level[64 +: 32] !== resp_data[2] || almost_full[2] !== 1'b0) begin
      err++; $display("FAIL wr_state: got lvl=%0d af=%b expected lvl=%0d af=0", level[64 +: 32], almost_full[2], resp_data[2]);
    end
    wr[2] = 1'b0;
  endtask

  task automatic test_timeout();
    bit   found = 1'b0;
    bit   ok;
    exp_t e;
    for (int unsigned i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (csr_read[3]) found = 1'b1;
    end
    hold[3] = 1'b1;
    repeat (64) @(negedge clk);
    cmp++;
    if (!found || {timeout_err[3], almost_full[3]} !== 2'b00) begin
      err++; $display("FAIL tout_early: got tout=%b af=%b expected 0 0", timeout_err[3], almost_full[3]);
    end
    @(negedge clk);
    cmp++;
    if ({timeout_err[3], almost_full[3], assert_cnt[12 +: 4], level[96 +: 32]} !== {1'b1, 1'b1, 4'd1, 32'd0}) begin
      err++;
      $display("FAIL tout_fire: got tout=%b af=%b cnt=%0d lvl=%0d expected 1 1 1 0",
               timeout_err[3], almost_full[3], assert_cnt[12 +: 4], level[96 +: 32]);
    end
    m_af[3]  = 1'b1;
    m_cnt[3] = 1;
    hold[3]  = 1'b0;
    send_level(3, 32'd100, ok);
    e = sb.pop_front();
    cmp++;
    if (!ok || {almost_full[3], assert_cnt[12 +: 4], level[96 +: 32]} !== {e.af, e.cnt, e.lvl}) begin
      err++;
      $display("FAIL tout_recover: got ok=%b af=%b cnt=%0d lvl=%0d expected af=%b cnt=%0d lvl=%0d",
               ok, almost_full[3], assert_cnt[12 +: 4], level[96 +: 32], e.af, e.cnt, e.lvl);
    end
    cmp++;
    if (timeout_err[3] !== 1'b1 || almost_full_any !== 1'b1) begin
      err++; $display("FAIL tout_sticky: got tout=%b any=%b expected 1 1", timeout_err[3], almost_full_any);
    end
  endtask

  task automatic test_saturation();
    bit   ok;
    exp_t e;
    for (int unsigned i = 0; i < 40; i++) begin
      send_level(0, (i % 2 == 0) ? 32'd500 : 32'd400, ok);
      e = sb.pop_front();
      cmp++;
      if (!ok || {almost_full[0], assert_cnt[0 +: 4], level[0 +: 32]} !== {e.af, e.cnt, e.lvl}) begin
        err++;
        $display("FAIL sat[%0d]: got ok=%b af=%b cnt=%0d lvl=%0d expected af=%b cnt=%0d lvl=%0d",
                 i, ok, almost_full[0], assert_cnt[0 +: 4], level[0 +: 32], e.af, e.cnt, e.lvl);
      end
    end
    cmp++;
    if (assert_cnt[0 +: 4] !== 4'd15) begin
      err++; $display("FAIL sat_final: got %0d expected 15", assert_cnt[0 +: 4]);
    end
  endtask

  task automatic test_poll_gap();
    logic prev;
    bit   found;
    int   period;
    for (int unsigned k = 0; k < 2; k++) begin
      found = 1'b0;
      prev  = g_read;
      for (int unsigned i = 0; i < 30 && !found; i++) begin
        @(negedge clk);
        if (g_read && !prev) found = 1'b1;
        prev = g_read;
      end
      period = 0;
      found  = 1'b0;
      for (int unsigned i = 0; i < 30 && !found; i++) begin
        @(negedge clk);
        period++;
        if (g_read && !prev) found = 1'b1;
        prev = g_read;
      end
      cmp++;
      if (!found || period != 7) begin
        err++; $display("FAIL gap_period[%0d]: got %0d expected 7", k, period);
      end
    end
    cmp++;
    if (g_level !== 32'd300 || g_af !== 1'b0 || g_tout !== 1'b0) begin
      err++; $display("FAIL gap_level: got lvl=%0d af=%b tout=%b expected 300 0 0", g_level, g_af, g_tout);
    end
  endtask

  task automatic test_rst_mid_wait();
    bit   found = 1'b0;
    bit   ok;
    exp_t e;
    for (int unsigned i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (csr_read[0]) found = 1'b1;
    end
    hold[0] = 1'b1;
    repeat (3) @(negedge clk);
    cmp++;
    if (!found || csr_read[0] !== 1'b0) begin
      err++; $display("FAIL mid_wait: got csr_read=%b expected 0", csr_read[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    cmp++;
    if ({csr_read, almost_full, almost_full_any, timeout_err, g_read} !== '0 ||
        level !== '0 || assert_cnt !== '0) begin
      err++;
      $display("FAIL rst_mid: got rd=%b af=%b any=%b tout=%b lvl=%h cnt=%h expected all 0",
               csr_read, almost_full, almost_full_any, timeout_err, level, assert_cnt);
    end
    rst     = 1'b0;
    hold[0] = 1'b0;
    reset_model();
    send_level(0, 32'd495, ok);
    e = sb.pop_front();
    cmp++;
    if (!ok || {almost_full[0], assert_cnt[0 +: 4], level[0 +: 32]} !== {e.af, e.cnt, e.lvl}) begin
      err++;
      $display("FAIL rst_resume: got ok=%b af=%b cnt=%0d lvl=%0d expected af=%b cnt=%0d lvl=%0d",
               ok, almost_full[0], assert_cnt[0 +: 4], level[0 +: 32], e.af, e.cnt, e.lvl);
    end
  endtask

  initial begin
    test_reset();
    test_hysteresis();
    test_waitrequest();
    test_timeout();
    test_saturation();
    test_poll_gap();
    test_rst_mid_wait();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
